// File: rtl/vram_port_responder.sv
// vram_port_responder
// Memory-side responder for the VDP VRAM access bus. On each slot capture
// edge it latches one arbiter request. It then runs that request as a single
// handshaked 32-bit word transaction on the memory port, and returns read
// data to the VDP as a selected byte and as a full word.
//
// Memory port handshake: mem_req rises the cycle after a request is accepted.
// While mem_req is high, mem_addr/mem_we/mem_be/mem_wdata are stable. The
// transaction completes on the first rising edge that samples mem_ack=1, and
// mem_rdata is valid on that same edge. If a capture edge coincides with the
// ack, the next request is issued with no gap in mem_req. If a capture edge
// arrives with no ack, that new request is dropped and overrun is set.
module vram_port_responder #(
  parameter int ADDR_W = 17
) (
  input  logic              CLK21M,
  input  logic              RESET_N,
  input  logic [1:0]        DOTSTATE,
  input  logic [ADDR_W-1:0] IRAMADR,
  input  logic              PRAMWE_N,
  input  logic [7:0]        PRAMDBO,
  input  logic [31:0]       PRAMDBO_32,
  input  logic              vram_rd_32_mode,
  input  logic              vram_wr_32_mode,
  input  logic              overrun_clr,
  output logic              mem_req,
  output logic [ADDR_W-3:0] mem_addr,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic [7:0]        PRAMDBI,
  output logic [31:0]       PRAMDBI_32,
  output logic              rd_valid,
  output logic              overrun,
  output logic              o_dbg_state
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_capture;
  logic              w_accept;
  logic              w_drop;
  logic              w_complete;

  logic [ADDR_W-3:0] r_addr;
  logic              r_we;
  logic [3:0]        r_be;
  logic [31:0]       r_wdata;
  logic [1:0]        r_lane;
  logic              r_rd32;
  logic [7:0]        r_dbi;
  logic [31:0]       r_dbi32;
  logic              r_rd_valid;
  logic              r_overrun;

  logic              w_is_wr;
  logic [1:0]        w_lane;
  logic [3:0]        w_be_nxt;
  logic [31:0]       w_wdata_nxt;

  // Requests are sampled only in dot phases 00 (primary) and 11 (secondary).
  assign w_capture = (DOTSTATE == 2'b00) || (DOTSTATE == 2'b11);
  assign w_is_wr   = ~PRAMWE_N;
  assign w_lane    = IRAMADR[1:0];

  // Decode byte enables and write data for the request on the bus this cycle.
  always_comb begin
    w_be_nxt    = 4'hF;
    w_wdata_nxt = 32'h0;
    if (w_is_wr) begin
      if (vram_wr_32_mode) begin
        w_be_nxt    = 4'hF;
        w_wdata_nxt = PRAMDBO_32;
      end else begin
        w_be_nxt    = 4'b0001 << w_lane;
        w_wdata_nxt = {4{PRAMDBO}};
      end
    end
  end

  // Next-state and handshake decisions.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_drop      = 1'b0;
    w_complete  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_capture) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (mem_ack) begin
          w_complete = 1'b1;
          if (w_capture) begin
            w_accept = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else if (w_capture) begin
          w_drop = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register; reset abandons any in-flight transaction.
  always_ff @(posedge CLK21M or negedge RESET_N) begin
    if (!RESET_N) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Latch the request fields only when a request is accepted.
  always_ff @(posedge CLK21M or negedge RESET_N) begin
    if (!RESET_N) begin
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_be    <= 4'h0;
      r_wdata <= 32'h0;
      r_lane  <= 2'b00;
      r_rd32  <= 1'b0;
    end else if (w_accept) begin
      r_addr  <= IRAMADR[ADDR_W-1:2];
      r_we    <= w_is_wr;
      r_be    <= w_be_nxt;
      r_wdata <= w_wdata_nxt;
      r_lane  <= w_lane;
      r_rd32  <= vram_rd_32_mode;
    end
  end

  // Capture read data on completion, using the in-flight request's lane and width.
  always_ff @(posedge CLK21M or negedge RESET_N) begin
    if (!RESET_N) begin
      r_dbi      <= 8'hFF;
      r_dbi32    <= 32'hFFFF_FFFF;
      r_rd_valid <= 1'b0;
    end else if (w_complete && !r_we) begin
      r_dbi32    <= mem_rdata;
      r_dbi      <= r_rd32 ? mem_rdata[7:0] : mem_rdata[{r_lane, 3'b000} +: 8];
      r_rd_valid <= 1'b1;
    end else begin
      r_rd_valid <= 1'b0;
    end
  end

  // Sticky overrun flag; a drop on the same edge as a clear keeps it set.
  always_ff @(posedge CLK21M or negedge RESET_N) begin
    if (!RESET_N)         r_overrun <= 1'b0;
    else if (w_drop)      r_overrun <= 1'b1;
    else if (overrun_clr) r_overrun <= 1'b0;
  end

  assign mem_req     = (r_state == ST_BUSY);
  assign mem_addr    = r_addr;
  assign mem_we      = r_we;
  assign mem_be      = r_be;
  assign mem_wdata   = r_wdata;
  assign PRAMDBI     = r_dbi;
  assign PRAMDBI_32  = r_dbi32;
  assign rd_valid    = r_rd_valid;
  assign overrun     = r_overrun;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_vram_port_responder.sv
// Testbench for vram_port_responder: directed slot scenarios, then randomized
// traffic. Each cycle is compared against a transaction-level reference model.
module tb_vram_port_responder;

  logic        clk;
  logic        rst_n;
  logic [1:0]  dotstate;
  logic [16:0] iramadr;
  logic        pramwe_n;
  logic [7:0]  pramdbo;
  logic [31:0] pramdbo_32;
  logic        rd_32;
  logic        wr_32;
  logic        ovr_clr;
  logic        mem_req;
  logic [14:0] mem_addr;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [7:0]  pramdbi;
  logic [31:0] pramdbi_32;
  logic        rd_valid;
  logic        overrun;
  logic        dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state (transaction level).
  bit          m_busy;
  logic [14:0] m_addr;
  bit          m_we;
  logic [3:0]  m_be;
  logic [31:0] m_wdata;
  int          m_lane;
  bit          m_rd32;
  logic [7:0]  m_dbi;
  logic [31:0] m_dbi32;
  bit          m_rdv;
  bit          m_ovr;

  logic [31:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  vram_port_responder #(.ADDR_W(17)) dut (
    .CLK21M          (clk),
    .RESET_N         (rst_n),
    .DOTSTATE        (dotstate),
    .IRAMADR         (iramadr),
    .PRAMWE_N        (pramwe_n),
    .PRAMDBO         (pramdbo),
    .PRAMDBO_32      (pramdbo_32),
    .vram_rd_32_mode (rd_32),
    .vram_wr_32_mode (wr_32),
    .overrun_clr     (ovr_clr),
    .mem_req         (mem_req),
    .mem_addr        (mem_addr),
    .mem_we          (mem_we),
    .mem_be          (mem_be),
    .mem_wdata       (mem_wdata),
    .mem_ack         (mem_ack),
    .mem_rdata       (mem_rdata),
    .PRAMDBI         (pramdbi),
    .PRAMDBI_32      (pramdbi_32),
    .rd_valid        (rd_valid),
    .overrun         (overrun),
    .o_dbg_state     (dbg_state)
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_reset();
    m_busy  = 0;
    m_addr  = '0;
    m_we    = 0;
    m_be    = 4'h0;
    m_wdata = 32'h0;
    m_lane  = 0;
    m_rd32  = 0;
    m_dbi   = 8'hFF;
    m_dbi32 = 32'hFFFF_FFFF;
    m_rdv   = 0;
    m_ovr   = 0;
    exp_q.delete();
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    bit cap;
    bit done;
    cap  = (dotstate == 2'b00) || (dotstate == 2'b11);
    done = m_busy && mem_ack;
    m_rdv = 0;
    if (done && !m_we) begin
      m_dbi32 = mem_rdata;
      m_dbi   = m_rd32 ? mem_rdata[7:0] : 8'((mem_rdata >> (8 * m_lane)) & 32'hFF);
      m_rdv   = 1;
      exp_q.push_back(mem_rdata);
    end
    if (cap && m_busy && !mem_ack) begin
      m_ovr = 1;
    end else if (ovr_clr) begin
      m_ovr = 0;
    end
    if (cap && (!m_busy || mem_ack)) begin
      m_busy  = 1;
      m_addr  = 15'(iramadr / 4);
      m_we    = !pramwe_n;
      m_lane  = int'(iramadr % 4);
      m_rd32  = rd_32;
      if (pramwe_n) begin
        m_be = 4'hF;  m_wdata = 32'h0;
      end else if (wr_32) begin
        m_be = 4'hF;  m_wdata = pramdbo_32;
      end else begin
        m_be = 4'(1 << m_lane);  m_wdata = 32'(pramdbo) * 32'h0101_0101;
      end
    end else if (done) begin
      m_busy = 0;
    end
  endtask

  task automatic compare_all();
    logic [31:0] e;
    check("mem_req",    32'(mem_req),    32'(m_busy));
    check("mem_addr",   32'(mem_addr),   32'(m_addr));
    check("mem_we",     32'(mem_we),     32'(m_we));
    check("mem_be",     32'(mem_be),     32'(m_be));
    check("mem_wdata",  mem_wdata,       m_wdata);
    check("PRAMDBI",    32'(pramdbi),    32'(m_dbi));
    check("PRAMDBI_32", pramdbi_32,      m_dbi32);
    check("rd_valid",   32'(rd_valid),   32'(m_rdv));
    check("overrun",    32'(overrun),    32'(m_ovr));
    if (rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("rd_unexpected", 32'(rd_valid), 32'h0);
      end else begin
        e = exp_q.pop_front();
        check("rd_word_q", pramdbi_32, e);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic drive_req(input logic [1:0] ds, input logic [16:0] a, input logic we_n,
                           input logic [7:0] d8, input logic [31:0] d32,
                           input logic r32, input logic w32);
    dotstate   = ds;
    iramadr    = a;
    pramwe_n   = we_n;
    pramdbo    = d8;
    pramdbo_32 = d32;
    rd_32      = r32;
    wr_32      = w32;
  endtask

  task automatic drive_mem(input logic ack, input logic [31:0] rd);
    mem_ack   = ack;
    mem_rdata = rd;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0] ds_seq [4];
    ds_seq[0] = 2'b00; ds_seq[1] = 2'b01; ds_seq[2] = 2'b11; ds_seq[3] = 2'b10;

    rst_n = 1'b0;
    drive_req(2'b01, 17'h0, 1'b1, 8'h0, 32'h0, 1'b0, 1'b0);
    drive_mem(1'b0, 32'h0);
    ovr_clr = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    compare_all();
    rst_n = 1'b1;
    cycle();

    // Byte read, lane 1 of word 1.
    drive_req(2'b00, 17'h00005, 1'b1, 8'h00, 32'h0, 1'b0, 1'b0);
    cycle();
    check("rd_addr", 32'(mem_addr), 32'h0001);
    check("rd_be",   32'(mem_be),   32'hF);
    drive_req(2'b01, 17'h00000, 1'b1, 8'h00, 32'h0, 1'b0, 1'b0);
    drive_mem(1'b1, 32'hAABBCCDD);
    cycle();
    check("rd_byte",  32'(pramdbi), 32'hCC);
    check("rd_word",  pramdbi_32,   32'hAABBCCDD);
    check("rd_pulse", 32'(rd_valid), 32'h1);
    drive_mem(1'b0, 32'h0);
    cycle();
    check("rd_pulse_end", 32'(rd_valid), 32'h0);

    // Byte write to the top lane of the top word.
    drive_req(2'b00, 17'h1FFFF, 1'b0, 8'h5A, 32'h0, 1'b0, 1'b0);
    cycle();
    check("bw_addr",  32'(mem_addr), 32'h7FFF);
    check("bw_be",    32'(mem_be),   32'h8);
    check("bw_wdata", mem_wdata,     32'h5A5A5A5A);
    check("bw_we",    32'(mem_we),   32'h1);
    drive_req(2'b01, 17'h0, 1'b1, 8'h0, 32'h0, 1'b0, 1'b0);
    drive_mem(1'b1, 32'h01020304);
    cycle();
    check("bw_no_rdv", 32'(rd_valid), 32'h0);
    check("bw_dbi",    32'(pramdbi),  32'hCC);
    drive_mem(1'b0, 32'h0);

    // Word write.
    drive_req(2'b00, 17'h00102, 1'b0, 8'h00, 32'h12345678, 1'b0, 1'b1);
    cycle();
    check("ww_addr",  32'(mem_addr), 32'h0040);
    check("ww_be",    32'(mem_be),   32'hF);
    check("ww_wdata", mem_wdata,     32'h12345678);
    drive_req(2'b01, 17'h0, 1'b1, 8'h0, 32'h0, 1'b0, 1'b0);
    drive_mem(1'b1, 32'h0);
    cycle();
    drive_mem(1'b0, 32'h0);

    // Back-to-back: ack coincides with the secondary capture.
    drive_req(2'b00, 17'h00012, 1'b1, 8'h0, 32'h0, 1'b0, 1'b0);
    cycle();
    drive_req(2'b01, 17'h0, 1'b1, 8'h0, 32'h0, 1'b0, 1'b0);
    cycle();
    drive_req(2'b11, 17'h00020, 1'b1, 8'h0, 32'h0, 1'b1, 1'b0);
    drive_mem(1'b1, 32'h11223344);
    cycle();
    check("b2b_req",  32'(mem_req),  32'h1);
    check("b2b_addr", 32'(mem_addr), 32'h0008);
    check("b2b_byte", 32'(pramdbi),  32'h22);
    check("b2b_ovr",  32'(overrun),  32'h0);
    drive_req(2'b10, 17'h0, 1'b1, 8'h0, 32'h0, 1'b0, 1'b0);
    drive_mem(1'b1, 32'h99887766);
    cycle();
    check("b2b_byte2", 32'(pramdbi), 32'h66);
    check("b2b_done",  32'(mem_req), 32'h0);
    drive_mem(1'b0, 32'h0);

    // Overrun: ack withheld across the next capture.
    drive_req(2'b00, 17'h00100, 1'b1, 8'h0, 32'h0, 1'b0, 1'b0);
    cycle();
    drive_req(2'b11, 17'h00200, 1'b1, 8'h0, 32'h0, 1'b0, 1'b0);
    cycle();
    check("ovr_set",  32'(overrun),  32'h1);
    check("ovr_addr", 32'(mem_addr), 32'h0040);
    drive_req(2'b00, 17'h00300, 1'b1, 8'h0, 32'h0, 1'b0, 1'b0);
    ovr_clr = 1'b1;
    cycle();
    check("ovr_set_wins", 32'(overrun), 32'h1);
    drive_req(2'b01, 17'h0, 1'b1, 8'h0, 32'h0, 1'b0, 1'b0);
    cycle();
    check("ovr_cleared", 32'(overrun), 32'h0);
    ovr_clr = 1'b0;
    drive_mem(1'b1, 32'hCAFEF00D);
    cycle();
    drive_mem(1'b0, 32'h0);

    // Reset while a transaction is in flight.
    drive_req(2'b00, 17'h00444, 1'b1, 8'h0, 32'h0, 1'b0, 1'b0);
    cycle();
    check("pre_rst_req", 32'(mem_req), 32'h1);
    drive_req(2'b01, 17'h0, 1'b1, 8'h0, 32'h0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_req",   32'(mem_req),   32'h0);
    check("rst_dbi",   32'(pramdbi),   32'hFF);
    check("rst_dbi32", pramdbi_32,     32'hFFFF_FFFF);
    check("rst_ovr",   32'(overrun),   32'h0);
    compare_all();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive_req(2'b00, 17'h00888, 1'b1, 8'h0, 32'h0, 1'b0, 1'b0);
    cycle();
    check("post_rst_req",  32'(mem_req),  32'h1);
    check("post_rst_addr", 32'(mem_addr), 32'h0222);
    drive_req(2'b01, 17'h0, 1'b1, 8'h0, 32'h0, 1'b0, 1'b0);
    drive_mem(1'b1, 32'h0BADBEEF);
    cycle();

    // Randomized traffic following the dot-phase sequence.
    for (int i = 0; i < 3000; i++) begin
      drive_req(ds_seq[i % 4], 17'($urandom_range(0, 17'h1FFFF)), 1'($urandom_range(0, 1)),
                8'($urandom), $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if (m_busy) drive_mem(1'($urandom_range(0, 3) != 0), $urandom);
      else        drive_mem(1'($urandom_range(0, 7) == 0), $urandom);
      ovr_clr = 1'($urandom_range(0, 7) == 0);
      cycle();
    end

    drive_req(2'b01, 17'h0, 1'b1, 8'h0, 32'h0, 1'b0, 1'b0);
    drive_mem(1'b0, 32'h0);
    ovr_clr = 1'b0;
    cycle();
    check("rd_queue_drained", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
